icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped instruction cache; the responder side of the fetch stage's word-address / instruction / hit interface.
- Serves instruction words to the fetch stage in the same cycle on a hit.
- On a miss, holds hit low while a refill FSM pulls the whole block from main memory through a req/ready handshake.
- Sits between the fetch stage and the unified memory model.

Parameters:
- LINES, 32, number of cache lines; must be a power of 2; IDX_W = log2(LINES).
- WORDS, 4, 32-bit words per block; must be a power of 2; OFF_W = log2(WORDS).
- TAG_W, 30-IDX_W-OFF_W (23 at defaults), derived tag width; not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  fetch request valid this cycle.
- addr  in  30  word address from the PC (byte address bits [31:2]).
- ins  out  32  instruction word; valid only when hit=1.
- hit  out  1  requested word is present in ins this cycle.
- mem_req  out  1  refill request to memory; held high for the whole refill.
- mem_addr  out  30  word address of the current refill beat.
- mem_data  in  32  memory read data; sampled when mem_ready=1.
- mem_ready  in  1  memory beat valid; one word per cycle when high.

Behaviour:
- Address split: offset = addr[OFF_W-1:0]; index = addr[OFF_W+IDX_W-1:OFF_W]; tag = addr[29:OFF_W+IDX_W].
- Storage: data array LINES x WORDS x 32; tag array LINES x TAG_W; valid bit per line.
- Reset (async): all valid bits=0; state=IDLE; beat counter=0; hit=0; ins=0; mem_req=0; mem_addr=0. Data and tag arrays are not cleared.
- IDLE state:
  - hit = rd_en & valid[index] & (tag_array[index]==tag), combinational, zero-cycle latency.
  - ins = selected word when hit=1, else 0.
  - If rd_en=1 and hit=0: latch miss_tag and miss_index; counter=0; go to REFILL next edge.
- REFILL state:
  - hit=0 and ins=0 regardless of addr.
  - mem_req=1; mem_addr = {miss_tag, miss_index, counter}.
  - On an edge with mem_ready=1: write mem_data to data[miss_index][counter]; counter+1.
  - mem_ready=0 stalls the FSM indefinitely, with mem_addr held.
  - On the beat where counter==WORDS-1: write tag_array[miss_index]=miss_tag, set valid[miss_index]=1, counter wraps to 0, go to DONE.
- DONE state: one bubble cycle; mem_req=0; hit=0. Next edge goes to IDLE.
- Miss penalty with zero-wait memory: WORDS+2 cycles from the miss cycle to the hit cycle (6 at defaults).
- Boundaries:
  - addr or rd_en changes during REFILL: ignored; the latched block completes.
  - After DONE the current addr is re-evaluated and may miss again (e.g. a branch during refill).
  - Conflict miss: the new block overwrites the line unconditionally; the valid bit stays 1 throughout.
  - Address wrap: addr=30'h3FFFFFFF is a legal address; the refill covers that block's beats only, with no carry into the tag.
  - rst asserted mid-refill: immediate IDLE; all lines invalid; a partial block is never marked valid.
  - rd_en=0 in IDLE: hit=0; no state change.

Decomposition:
- Package icache_pkg holds:
  - IDLE/REFILL/DONE state encoding (2-bit).
  - Default LINES and WORDS values.
  - Address field-slice helper functions.
- One sub-module, icache_data_ram: LINES*WORDS x 32 array with async read and sync write. Keeps it swappable for a block RAM.
- Tag/valid arrays and the FSM stay in the top module.

Test Plan:
- Cold miss. Reset, rd_en=1, addr=0, memory returns word i = 32'h1000_0000+i, mem_ready=1 always. Required:
  - mem_req high for 4 cycles with mem_addr 0,1,2,3.
  - One DONE cycle.
  - Next cycle hit=1, ins=32'h1000_0000.
- Same-block hits. After the cold miss, addr=1,2,3 on consecutive cycles -> hit=1 each cycle, ins=32'h1000_0001/2/3, mem_req stays 0.
- Conflict miss. addr=128 maps to index 0 with tag 1. Required:
  - Refill fetches 128..131.
  - Then addr=128 hits.
  - Then addr=0 misses and refills again.
- Stalled memory. mem_ready toggles 1,0,0,1,1,0,1 during refill. Required:
  - mem_addr advances only after ready beats.
  - Completion follows the 4th ready beat.
  - Data is correct at all 4 offsets.
- Redirect mid-refill. Miss on addr=31; change addr to 64 during the 2nd beat. Required:
  - Block 28..31 completes and becomes valid.
  - After DONE, addr=64 misses and refills 64..67.
- Reset mid-refill. Assert rst after 2 beats. Required:
  - mem_req drops asynchronously.
  - After release, addr=0 misses (valid cleared) and refills from beat 0.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Brief    : Shared constants, refill state encoding and address-field helper
//            for the direct-mapped instruction cache.
// Revision : 1.0
// ============================================================================
package icache_pkg;

    localparam int c_lines_default = 32;
    localparam int c_words_default = 4;

    localparam int          c_state_w = 2;
    localparam logic [1:0]  c_idle    = 2'd0;
    localparam logic [1:0]  c_refill  = 2'd1;
    localparam logic [1:0]  c_done    = 2'd2;

    // Extracts a right-justified bit field of a 30-bit word address.
    function automatic logic [29:0] addr_field(input logic [29:0] addr,
                                               input int          lsb,
                                               input int          width);
        return (addr >> lsb) & ((30'd1 << width) - 30'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_data_ram.sv
`default_nettype none
// ============================================================================
// Module   : icache_data_ram
// Brief    : Instruction data store, async read / sync write, kept separate so
//            it can be swapped for a block RAM.
// Revision : 1.0
// ============================================================================
module icache_data_ram #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder
// Brief    : Direct-mapped instruction cache: zero-latency hits, whole-block
//            refill from memory over a req/ready handshake on a miss.
// Revision : 1.0
// ============================================================================
module icache_responder
    import icache_pkg::*;
#(
    parameter int LINES = c_lines_default,
    parameter int WORDS = c_words_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [29:0] addr,
    output logic [31:0] ins,
    output logic        hit,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_ready
);

    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = 30 - IDX_W - OFF_W;

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_next;
    logic [LINES-1:0]     r_valid;
    logic [TAG_W-1:0]     r_tag_array [LINES];
    logic [TAG_W-1:0]     r_miss_tag;
    logic [IDX_W-1:0]     r_miss_index;
    logic [OFF_W-1:0]     r_count;

    logic [OFF_W-1:0]     w_offset;
    logic [IDX_W-1:0]     w_index;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit;
    logic                 w_we;
    logic                 w_last;
    logic [29:0]          w_mem_addr;
    logic                 w_mem_req;
    logic [31:0]          w_rdata;

    assign w_offset = OFF_W'(addr_field(addr, 0, OFF_W));
    assign w_index  = IDX_W'(addr_field(addr, OFF_W, IDX_W));
    assign w_tag    = TAG_W'(addr_field(addr, OFF_W + IDX_W, TAG_W));

    always_comb begin
        w_state_next = r_state;
        w_hit        = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_addr   = '0;
        w_we         = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            c_idle: begin
                w_hit = rd_en & r_valid[w_index] & (r_tag_array[w_index] == w_tag);
                if (rd_en && !w_hit) begin
                    w_state_next = c_refill;
                end
            end
            c_refill: begin
                w_mem_req  = 1'b1;
                w_mem_addr = {r_miss_tag, r_miss_index, r_count};
                w_we       = mem_ready;
                w_last     = mem_ready && (r_count == OFF_W'(WORDS - 1));
                if (w_last) begin
                    w_state_next = c_done;
                end
            end
            c_done:  w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_idle;
            r_valid      <= '0;
            r_count      <= '0;
            r_miss_tag   <= '0;
            r_miss_index <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_idle && rd_en && !w_hit) begin
                r_miss_tag   <= w_tag;
                r_miss_index <= w_index;
                r_count      <= '0;
            end
            if (w_we) begin
                r_count <= r_count + OFF_W'(1);
            end
            // Valid is only raised once the final beat lands, so a reset
            // mid-refill can never expose a partial block.
            if (w_last) begin
                r_valid[r_miss_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_last) begin
            r_tag_array[r_miss_index] <= r_miss_tag;
        end
    end

    icache_data_ram #(
        .DEPTH  (LINES * WORDS),
        .ADDR_W (IDX_W + OFF_W)
    ) u_data_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr ({r_miss_index, r_count}),
        .i_wdata (mem_data),
        .i_raddr ({w_index, w_offset}),
        .o_rdata (w_rdata)
    );

    assign hit      = w_hit;
    assign ins      = w_hit ? w_rdata : 32'd0;
    assign mem_req  = w_mem_req;
    assign mem_addr = w_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_responder
// Brief    : Directed self-checking bench for icache_responder.
// Revision : 1.0
// ============================================================================
module tb_icache_responder;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [29:0] addr;
    logic [31:0] ins;
    logic        hit;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;

    int total;
    int bad;

    icache_responder dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .addr      (addr),
        .ins       (ins),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at address a holds 0x1000_0000 + a.
    assign mem_data = 32'h1000_0000 + {2'b00, mem_addr};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic rd, input logic [29:0] a, input logic rdy);
        rd_en     = rd;
        addr      = a;
        mem_ready = rdy;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered in the first REFILL cycle with mem_ready=1; leaves in IDLE.
    task automatic expect_refill(input logic [29:0] blk);
        for (int i = 0; i < 4; i++) begin
            chk("refill_req", 32'(mem_req), 32'd1);
            chk("refill_addr", 32'(mem_addr), 32'(blk) + 32'(i));
            chk("refill_hit", 32'(hit), 32'd0);
            tick();
        end
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_hit", 32'(hit), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] pat;
        int         beats;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b0, 30'd0, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        tick();
        rst = 1'b0;

        // Cold miss on address 0
        drive(1'b1, 30'd0, 1'b1);
        chk("cold_miss_hit", 32'(hit), 32'd0);
        chk("cold_miss_req", 32'(mem_req), 32'd0);
        tick();
        expect_refill(30'd0);
        chk("cold_hit", 32'(hit), 32'd1);
        chk("cold_ins", ins, 32'h1000_0000);

        // Same-block hits
        for (int i = 1; i < 4; i++) begin
            tick();
            drive(1'b1, 30'(i), 1'b1);
            chk("blk_hit", 32'(hit), 32'd1);
            chk("blk_ins", ins, 32'h1000_0000 + 32'(i));
            chk("blk_req", 32'(mem_req), 32'd0);
        end

        // rd_en low in IDLE
        tick();
        drive(1'b0, 30'd0, 1'b1);
        chk("idle_hit", 32'(hit), 32'd0);
        chk("idle_ins", ins, 32'd0);
        tick();
        chk("idle_req", 32'(mem_req), 32'd0);

        // Conflict miss: 128 -> index 0, tag 1
        drive(1'b1, 30'd128, 1'b1);
        chk("conf_miss", 32'(hit), 32'd0);
        tick();
        expect_refill(30'd128);
        chk("conf_hit", 32'(hit), 32'd1);
        chk("conf_ins", ins, 32'h1000_0080);
        tick();
        drive(1'b1, 30'd0, 1'b1);
        chk("conf_evict", 32'(hit), 32'd0);
        tick();
        expect_refill(30'd0);
        chk("conf_back_hit", 32'(hit), 32'd1);
        chk("conf_back_ins", ins, 32'h1000_0000);

        // Stalled memory on block 8..11
        tick();
        drive(1'b1, 30'd8, 1'b1);
        chk("stall_miss", 32'(hit), 32'd0);
        tick();
        pat   = 7'b1011001;   // bit k = ready in refill cycle k: 1,0,0,1,1,0,1
        beats = 0;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 30'd8, pat[k]);
            chk("stall_req", 32'(mem_req), 32'd1);
            chk("stall_addr", 32'(mem_addr), 32'd8 + 32'(beats));
            beats += int'(pat[k]);
            tick();
        end
        chk("stall_done_req", 32'(mem_req), 32'd0);
        drive(1'b1, 30'd8, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 30'd8 + 30'(i), 1'b1);
            chk("stall_hit", 32'(hit), 32'd1);
            chk("stall_ins", ins, 32'h1000_0008 + 32'(i));
        end

        // Redirect mid-refill
        tick();
        drive(1'b1, 30'd31, 1'b1);
        chk("redir_miss", 32'(hit), 32'd0);
        tick();
        chk("redir_b0", 32'(mem_addr), 32'd28);
        tick();
        drive(1'b1, 30'd64, 1'b1);
        chk("redir_b1", 32'(mem_addr), 32'd29);
        chk("redir_b1_hit", 32'(hit), 32'd0);
        tick();
        chk("redir_b2", 32'(mem_addr), 32'd30);
        tick();
        chk("redir_b3", 32'(mem_addr), 32'd31);
        tick();
        chk("redir_done_req", 32'(mem_req), 32'd0);
        tick();
        chk("redir_new_miss", 32'(hit), 32'd0);
        tick();
        expect_refill(30'd64);
        chk("redir_hit64", 32'(hit), 32'd1);
        chk("redir_ins64", ins, 32'h1000_0040);
        drive(1'b1, 30'd31, 1'b1);
        chk("redir_hit31", 32'(hit), 32'd1);
        chk("redir_ins31", ins, 32'h1000_001F);

        // Top-of-address-space block
        tick();
        drive(1'b1, 30'h3FFF_FFFF, 1'b1);
        chk("wrap_miss", 32'(hit), 32'd0);
        tick();
        expect_refill(30'h3FFF_FFFC);
        chk("wrap_hit", 32'(hit), 32'd1);
        chk("wrap_ins", ins, 32'h4FFF_FFFF);

        // Reset mid-refill
        tick();
        drive(1'b1, 30'd128, 1'b1);
        tick();
        tick();
        tick();
        chk("rstmid_addr", 32'(mem_addr), 32'd130);
        rst = 1'b1;
        #1;
        chk("rstmid_req", 32'(mem_req), 32'd0);
        chk("rstmid_hit", 32'(hit), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_partial", 32'(hit), 32'd0);
        drive(1'b1, 30'd0, 1'b1);
        chk("rstmid_cleared", 32'(hit), 32'd0);
        tick();
        expect_refill(30'd0);
        chk("rstmid_hit0", 32'(hit), 32'd1);
        chk("rstmid_ins0", ins, 32'h1000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
